// File: rtl/ypc_ctrl.sv
// ypc_ctrl -- multi-cycle instruction sequencer for a small core.
//
// Walks IDLE -> FETCH -> WAIT -> EXEC -> WB -> FETCH ... until an ebreak
// (HALT) or a fetch stall timeout (ERR). Both terminal states hold until
// reset.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   start               leave IDLE and begin execution
//   ifu_req_*           fetch request channel (valid/ready, addr = pc)
//   ifu_rsp_*           fetch response channel (ready only in WAIT)
//   inst                latched instruction, feeds the external decoder
//   dec_*               combinational decode of inst
//   alu_result          rs1_data + imm from the datapath
//   rf_wen, rf_wdata    register-file write strobe (WB only) and data
//   pc, ret, instret    program counter, last ALU result, retired count
//   halt, err, state    sticky status and the current FSM state
module ypc_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_req_addr,
    input  logic        ifu_rsp_valid,
    output logic        ifu_rsp_ready,
    input  logic [31:0] ifu_rsp_inst,
    output logic [31:0] inst,
    input  logic        dec_isbreak,
    input  logic        dec_aluop,
    input  logic        dec_regWriteEn,
    input  logic [31:0] alu_result,
    output logic        rf_wen,
    output logic [31:0] rf_wdata,
    output logic [31:0] pc,
    output logic [31:0] ret,
    output logic [31:0] instret,
    output logic        halt,
    output logic        err,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WB    = 3'd4,
        ST_HALT  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] ret_reg, ret_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] instret_reg, instret_next;
    logic [31:0] wait_cnt_reg, wait_cnt_next;
    logic        halt_reg, halt_next;
    logic        err_reg, err_next;
    logic        timeout;

    // The current stalled cycle is the one that reaches the limit.
    assign timeout = (wait_cnt_reg + 32'd1) >= FETCH_TIMEOUT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= RESET_PC;
            inst_reg     <= '0;
            ret_reg      <= '0;
            wdata_reg    <= '0;
            instret_reg  <= '0;
            wait_cnt_reg <= '0;
            halt_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            inst_reg     <= inst_next;
            ret_reg      <= ret_next;
            wdata_reg    <= wdata_next;
            instret_reg  <= instret_next;
            wait_cnt_reg <= wait_cnt_next;
            halt_reg     <= halt_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        inst_next     = inst_reg;
        ret_next      = ret_reg;
        wdata_next    = wdata_reg;
        instret_next  = instret_reg;
        wait_cnt_next = wait_cnt_reg;
        halt_next     = halt_reg;
        err_next      = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_FETCH;
                    wait_cnt_next = '0;
                end
            end
            ST_FETCH: begin
                if (ifu_req_ready) begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = '0;
                end else if (timeout) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                    halt_next  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 32'd1;
                end
            end
            ST_WAIT: begin
                if (ifu_rsp_valid) begin
                    inst_next  = ifu_rsp_inst;
                    state_next = ST_EXEC;
                end else if (timeout) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                    halt_next  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 32'd1;
                end
            end
            ST_EXEC: begin
                if (dec_isbreak) begin
                    // ebreak retires nothing: pc and instret stay put.
                    state_next = ST_HALT;
                    halt_next  = 1'b1;
                end else begin
                    if (dec_aluop) begin
                        ret_next   = alu_result;
                        wdata_next = alu_result;
                    end
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                pc_next       = pc_reg + 32'd4;
                instret_next  = instret_reg + 32'd1;
                state_next    = ST_FETCH;
                wait_cnt_next = '0;
            end
            ST_HALT: begin
                halt_next = 1'b1;
            end
            ST_ERR: begin
                halt_next = 1'b1;
                err_next  = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Channel handshakes and the write strobe decode straight from state so
    // they drop the instant reset is asserted.
    assign ifu_req_valid = (state_reg == ST_FETCH);
    assign ifu_req_addr  = pc_reg;
    assign ifu_rsp_ready = (state_reg == ST_WAIT);
    assign rf_wen        = (state_reg == ST_WB) && dec_regWriteEn && dec_aluop;
    assign rf_wdata      = wdata_reg;
    assign inst          = inst_reg;
    assign pc            = pc_reg;
    assign ret           = ret_reg;
    assign instret       = instret_reg;
    assign halt          = halt_reg;
    assign err           = err_reg;
    assign state         = state_reg;

endmodule

// File: tb/tb_ypc_ctrl.sv
// Testbench for ypc_ctrl: a bench-side decoder/datapath and memory model
// drive the main instance; expected register-file writes are queued when an
// instruction is returned and popped when rf_wen is seen. A second instance
// with RESET_PC = FFFF_FFFC checks pc wrap-around.
module tb_ypc_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_req_addr, ifu_rsp_inst, inst, alu_result, rf_wdata;
    logic [31:0] pc, ret, instret;
    logic        dec_isbreak, dec_aluop, dec_regWriteEn, rf_wen, halt, err;
    logic [2:0]  state;

    logic        w_start, w_req_valid, w_rsp_ready, w_isbreak, w_aluop, w_regwen;
    logic        w_rf_wen, w_halt, w_err;
    logic [31:0] w_req_addr, w_inst, w_alu_result, w_rf_wdata, w_pc, w_ret, w_instret;
    logic [2:0]  w_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wen_count = 0;
    logic [31:0] mem [0:15];
    logic [31:0] exp_pc;
    logic [31:0] sb_q [$];
    int          stall_cycles;
    logic        rsp_enable;

    always #5 clk = ~clk;

    // Bench decoder and datapath: programs only use rs1 = x0.
    function automatic logic f_brk(input logic [31:0] i);
        return i == 32'h0010_0073;
    endfunction
    function automatic logic f_alu(input logic [31:0] i);
        return i[6:0] == 7'b0010011;
    endfunction
    function automatic logic f_wen(input logic [31:0] i);
        return f_alu(i) && (i[11:7] != 5'd0);
    endfunction
    function automatic logic [31:0] f_imm(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    assign dec_isbreak    = f_brk(inst);
    assign dec_aluop      = f_alu(inst);
    assign dec_regWriteEn = f_wen(inst);
    assign alu_result     = f_imm(inst);
    assign w_isbreak      = f_brk(w_inst);
    assign w_aluop        = f_alu(w_inst);
    assign w_regwen       = f_wen(w_inst);
    assign w_alu_result   = f_imm(w_inst);

    ypc_ctrl #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(8)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_inst(ifu_rsp_inst),
        .inst(inst), .dec_isbreak(dec_isbreak), .dec_aluop(dec_aluop),
        .dec_regWriteEn(dec_regWriteEn), .alu_result(alu_result),
        .rf_wen(rf_wen), .rf_wdata(rf_wdata), .pc(pc), .ret(ret), .instret(instret),
        .halt(halt), .err(err), .state(state)
    );

    ypc_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .start(w_start),
        .ifu_req_valid(w_req_valid), .ifu_req_ready(1'b1), .ifu_req_addr(w_req_addr),
        .ifu_rsp_valid(1'b1), .ifu_rsp_ready(w_rsp_ready), .ifu_rsp_inst(32'h0070_0093),
        .inst(w_inst), .dec_isbreak(w_isbreak), .dec_aluop(w_aluop),
        .dec_regWriteEn(w_regwen), .alu_result(w_alu_result),
        .rf_wen(w_rf_wen), .rf_wdata(w_rf_wdata), .pc(w_pc), .ret(w_ret), .instret(w_instret),
        .halt(w_halt), .err(w_err), .state(w_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    // Memory model plus rf write monitor, evaluated on every falling edge.
    initial begin : memory_model
        int   stall_left;
        logic hs_prev;
        logic [31:0] word;
        stall_left = 0;
        hs_prev    = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ifu_req_ready = 1'b0;
                if (rsp_enable) ifu_rsp_valid = 1'b0;
                stall_left = stall_cycles;
                hs_prev    = 1'b0;
            end else begin
                if (rf_wen) begin
                    wen_count++;
                    if (sb_q.size() == 0) check("rf_wen_unexpected", 32'd1, 32'd0);
                    else begin
                        word = sb_q.pop_front();
                        check("rf_wdata", rf_wdata, word);
                        check("ret_at_wb", ret, word);
                    end
                end
                if (hs_prev) check("wait_after_hs", {29'd0, state}, 32'd2);
                hs_prev = 1'b0;
                if (ifu_req_valid) begin
                    check("req_addr", ifu_req_addr, exp_pc);
                    if (stall_left > 0) begin
                        ifu_req_ready = 1'b0;
                        stall_left--;
                    end else begin
                        ifu_req_ready = 1'b1;
                        hs_prev       = 1'b1;
                        stall_left    = stall_cycles;
                    end
                end else begin
                    ifu_req_ready = 1'b0;
                end
                if (rsp_enable) begin
                    if (ifu_rsp_ready) begin
                        word          = mem[exp_pc[5:2]];
                        ifu_rsp_valid = 1'b1;
                        ifu_rsp_inst  = word;
                        if (f_wen(word)) sb_q.push_back(f_imm(word));
                        if (!f_brk(word)) exp_pc = exp_pc + 32'd4;
                    end else begin
                        ifu_rsp_valid = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        exp_pc = 32'd0;
        sb_q.delete();
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {29'd0, state}, {29'd0, s});
    endtask

    initial begin : main
        int wait_cycles, n, wen_before;
        reset = 1'b0; start = 1'b0; w_start = 1'b0;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = '0;
        rsp_enable = 1'b1; stall_cycles = 0; exp_pc = 32'd0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0010_0073;
        repeat (2) @(negedge clk);
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_ret", ret, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_flags", {28'd0, halt, err, rf_wen, ifu_req_valid}, 32'd0);
        check("rst_rsp_ready", {31'd0, ifu_rsp_ready}, 32'd0);
        check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        #2 reset = 1'b1;

        // Wrap instance: one addi starting at FFFF_FFFC; main stays in IDLE.
        @(negedge clk);
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        check("wrap_fetch_addr", w_req_addr, 32'hFFFF_FFFC);
        check("wrap_fetch_valid", {31'd0, w_req_valid}, 32'd1);
        @(negedge clk);
        check("wrap_rsp_ready", {31'd0, w_rsp_ready}, 32'd1);
        repeat (2) @(negedge clk);
        check("wrap_wb_wen", {31'd0, w_rf_wen}, 32'd1);
        check("wrap_wb_wdata", w_rf_wdata, 32'd7);
        check("wrap_wb_pc", w_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_pc", w_pc, 32'd0);
        check("wrap_instret", w_instret, 32'd1);
        check("wrap_ret", w_ret, 32'd7);
        check("wrap_state", {29'd0, w_state}, 32'd1);
        check("wrap_flags", {30'd0, w_halt, w_err}, 32'd0);
        check("idle_hold", {29'd0, state}, 32'd0);

        // addi x1,x0,5 ; ebreak with zero-wait memory.
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0073;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("t1_halt_by_8", {31'd0, halt}, 32'd1);
        check("t1_state", {29'd0, state}, 32'd5);
        check("t1_pc", pc, 32'd4);
        check("t1_instret", instret, 32'd1);
        check("t1_ret", ret, 32'd5);
        check("t1_wdata", rf_wdata, 32'd5);
        check("t1_err", {31'd0, err}, 32'd0);
        check("t1_wen_count", wen_count, 32'd1);
        check("t1_sb_empty", sb_q.size(), 32'd0);
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("halt_sticky", {28'd0, state, ifu_req_valid}, {28'd0, 3'd5, 1'b0});
        end
        start = 1'b0;

        // Request stalls of 3 cycles; addi x0 (no write), negative addi,
        // non-ALU instruction (ret/rf_wdata hold), ebreak.
        mem[0] = 32'h0010_0013;
        mem[1] = 32'hFFD0_0113;
        mem[2] = 32'h1234_5037;
        mem[3] = 32'h0010_0073;
        stall_cycles = 3;
        do_reset();
        wen_count = 0;
        pulse_start();
        wait_state(3'd5, 150, "t2_halt");
        check("t2_pc", pc, 32'd12);
        check("t2_instret", instret, 32'd3);
        check("t2_ret_hold", ret, 32'hFFFF_FFFD);
        check("t2_wdata_hold", rf_wdata, 32'hFFFF_FFFD);
        check("t2_wen_count", wen_count, 32'd1);
        check("t2_sb_empty", sb_q.size(), 32'd0);

        // Response never arrives: 8 stalled WAIT cycles then ERR.
        stall_cycles = 0;
        rsp_enable = 1'b0;
        ifu_rsp_valid = 1'b0;
        do_reset();
        wen_before = wen_count;
        pulse_start();
        wait_cycles = 0;
        n = 0;
        while (state != 3'd6 && n < 60) begin
            @(negedge clk);
            n++;
            if (state == 3'd2) wait_cycles++;
        end
        check("t3_err_state", {29'd0, state}, 32'd6);
        check("t3_wait_cycles", wait_cycles, 32'd8);
        check("t3_err_halt", {30'd0, err, halt}, 32'd3);
        repeat (3) @(negedge clk);
        check("t3_err_sticky", {28'd0, state, ifu_req_valid}, {28'd0, 3'd6, 1'b0});
        check("t3_no_wen", wen_count, wen_before);

        // Asynchronous reset during WAIT with a response pending.
        do_reset();
        pulse_start();
        wait_state(3'd2, 10, "t4_in_wait");
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'hDEAD_BEEF;
        #2 reset = 1'b0;
        #1;
        check("t4_async_state", {29'd0, state}, 32'd0);
        check("t4_async_flags", {28'd0, ifu_rsp_ready, ifu_req_valid, rf_wen, halt}, 32'd0);
        check("t4_async_pc", pc, 32'd0);
        @(posedge clk);
        #1;
        check("t4_inst_unchanged", inst, 32'd0);
        check("t4_state_held", {29'd0, state}, 32'd0);
        @(negedge clk);
        ifu_rsp_valid = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_idle_after", {29'd0, state}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
